tdc_interval_capture: RTL and testbench

- Stage directly downstream of the edge detectors: consumes the one-cycle start/stop pulses they produce.
- Freezes the delay-line thermometer code on each pulse and counts whole clk cycles between start and stop.
- Converts both frozen codes to fine tap counts and presents one measurement record per start/stop pair over a valid/ready handshake to the readout logic.

---
 rtl/tdc_pkg.sv | 41 ++++
 rtl/therm_popcount.sv | 51 +++++
 rtl/tdc_interval_capture.sv | 204 ++++++++++++++++++++
 tb/tb_tdc_interval_capture.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
// Shared definitions for the TDC interval-capture block:
//   - FSM state encoding used by tdc_interval_capture (IDLE/RUN/ENCODE/DONE)
//   - default parameter values (TAPS, FINE_W, COARSE_W, drop counter width)
//   - tdc_clog2(): constant-foldable ceil(log2) used for parameter sizing
// No ports; import with "import tdc_pkg::*;".
// -----------------------------------------------------------------------------
package tdc_pkg;

  // Default delay-line length and counter widths.
  localparam int TDC_TAPS_DEF     = 64;
  localparam int TDC_FINE_W_DEF   = 7;   // holds 0..64
  localparam int TDC_COARSE_W_DEF = 16;

  // Width of the optional dropped-pulse counter.
  localparam int TDC_DROP_W       = 16;

  // Measurement FSM encoding. The numeric values are visible on the
  // debug state output, so keep them fixed.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    ENCODE = 2'd2,
    DONE   = 2'd3
  } tdc_state_t;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int tdc_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/therm_popcount.sv
// -----------------------------------------------------------------------------
// therm_popcount
// Purely combinational ones-count of a thermometer code, built as a balanced
// binary adder tree. Counting ones (rather than locating the 0/1 boundary)
// makes the result tolerant of single-bit bubbles in the delay-line sample.
//
// Parameters:
//   TAPS   - width of the thermometer code
//   FINE_W - result width; must be able to hold the value TAPS
// Ports:
//   i_code  in  [TAPS-1:0]   thermometer code
//   o_count out [FINE_W-1:0] number of ones in i_code (0..TAPS)
// -----------------------------------------------------------------------------
module therm_popcount
  import tdc_pkg::*;
#(
  parameter int TAPS   = TDC_TAPS_DEF,
  parameter int FINE_W = TDC_FINE_W_DEF
) (
  input  logic [TAPS-1:0]   i_code,
  output logic [FINE_W-1:0] o_count
);

  // Tree depth, at least one level so the root is always an adder node.
  localparam int LVLS  = (tdc_clog2(TAPS) < 1) ? 1 : tdc_clog2(TAPS);
  localparam int NLEAF = 1 << LVLS;

  // Code zero-extended to a power-of-two leaf count; pad leaves read as 0.
  logic [NLEAF-1:0]  w_padded;
  // Heap-ordered tree: node n sums nodes 2n and 2n+1, leaves at NLEAF..2*NLEAF-1.
  logic [FINE_W-1:0] w_node [1:2*NLEAF-1];

  assign w_padded = NLEAF'(i_code);

  always_comb begin
    for (int n = 1; n < 2 * NLEAF; n++) begin
      w_node[n] = '0;
    end
    for (int i = 0; i < NLEAF; i++) begin
      w_node[NLEAF + i] = FINE_W'(w_padded[i]);
    end
    // Children always have larger indices, so walking downward computes
    // every operand before it is consumed.
    for (int n = NLEAF - 1; n >= 1; n--) begin
      w_node[n] = w_node[2 * n] + w_node[2 * n + 1];
    end
  end

  assign o_count = w_node[1];

endmodule

// File: rtl/tdc_interval_capture.sv
// -----------------------------------------------------------------------------
// tdc_interval_capture
// Sits behind the start/stop edge detectors of a delay-line TDC. On a start
// pulse it freezes the thermometer code and begins counting clk edges; on the
// stop pulse it freezes the code again and latches the count. One ENCODE cycle
// converts both frozen codes to ones-counts, then a single measurement record
// is offered to the readout logic.
//
// Optional feature (macro TDC_DROP_COUNT_EN):
//   adds output drop_count, a saturating count of pulses that could not be
//   used: start pulses while a measurement is in progress and stop pulses
//   while idle. Without the macro the port does not exist.
//
// Parameters: TAPS (delay-line taps), FINE_W (fine width, holds 0..TAPS),
//             COARSE_W (cycle counter width).
// Ports:
//   clk              in   system clock, rising edge
//   reset            in   synchronous, active-high
//   start_pulse      in   one-cycle start event
//   stop_pulse       in   one-cycle stop event
//   therm_code       in   [TAPS-1:0] registered delay-line sample
//   meas_ready       in   consumer accepts record
//   meas_valid       out  record available
//   meas_coarse      out  [COARSE_W-1:0] clk edges from start to stop capture
//   meas_fine_start  out  [FINE_W-1:0] ones-count of code at start
//   meas_fine_stop   out  [FINE_W-1:0] ones-count of code at stop (0 on timeout)
//   meas_timeout     out  counter saturated before a stop arrived
//   drop_count       out  [15:0] dropped pulses (TDC_DROP_COUNT_EN only)
//   dbg_state        out  [1:0] current FSM state (tdc_state_t encoding)
//   busy             out  state != IDLE
//
// Handshake: a record transfers on a rising edge where meas_valid and
// meas_ready are both high. meas_valid never drops and the record fields
// never change until that transfer; meas_ready may toggle freely and has no
// effect while meas_valid is low. After the transfer the fields keep their
// last values, and the block is idle from the next cycle on.
// -----------------------------------------------------------------------------
module tdc_interval_capture
  import tdc_pkg::*;
#(
  parameter int TAPS     = TDC_TAPS_DEF,
  parameter int FINE_W   = TDC_FINE_W_DEF,
  parameter int COARSE_W = TDC_COARSE_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_pulse,
  input  logic                  stop_pulse,
  input  logic [TAPS-1:0]       therm_code,
  input  logic                  meas_ready,
  output logic                  meas_valid,
  output logic [COARSE_W-1:0]   meas_coarse,
  output logic [FINE_W-1:0]     meas_fine_start,
  output logic [FINE_W-1:0]     meas_fine_stop,
  output logic                  meas_timeout,
`ifdef TDC_DROP_COUNT_EN
  output logic [TDC_DROP_W-1:0] drop_count,
`endif
  output logic [1:0]            dbg_state,
  output logic                  busy
);

  localparam logic [COARSE_W-1:0] CNT_MAX = '1;
  localparam logic [COARSE_W-1:0] CNT_ONE = COARSE_W'(1);

  // FSM and measurement state
  tdc_state_t          r_state;
  logic [COARSE_W-1:0] r_cnt;
  logic [COARSE_W-1:0] r_coarse;
  logic                r_timeout;
  logic [TAPS-1:0]     r_start_raw;
  logic [TAPS-1:0]     r_stop_raw;

  // Registered record outputs
  logic                r_meas_valid;
  logic [COARSE_W-1:0] r_meas_coarse;
  logic [FINE_W-1:0]   r_meas_fine_start;
  logic [FINE_W-1:0]   r_meas_fine_stop;
  logic                r_meas_timeout;

  // Ones-counts of the frozen codes
  logic [FINE_W-1:0]   w_fine_start;
  logic [FINE_W-1:0]   w_fine_stop;

  therm_popcount #(
    .TAPS   (TAPS),
    .FINE_W (FINE_W)
  ) u_pop_start (
    .i_code  (r_start_raw),
    .o_count (w_fine_start)
  );

  therm_popcount #(
    .TAPS   (TAPS),
    .FINE_W (FINE_W)
  ) u_pop_stop (
    .i_code  (r_stop_raw),
    .o_count (w_fine_stop)
  );

  // ---------------------------------------------------------------------------
  // Measurement FSM
  // r_cnt is loaded with 1 on the start edge and incremented on every RUN
  // edge without a stop, so a stop n edges after the start latches n.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= IDLE;
      r_cnt             <= '0;
      r_coarse          <= '0;
      r_timeout         <= 1'b0;
      r_start_raw       <= '0;
      r_stop_raw        <= '0;
      r_meas_valid      <= 1'b0;
      r_meas_coarse     <= '0;
      r_meas_fine_start <= '0;
      r_meas_fine_stop  <= '0;
      r_meas_timeout    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A stop in the same cycle as the start is simply ignored.
          if (start_pulse) begin
            r_start_raw <= therm_code;
            r_cnt       <= CNT_ONE;
            r_state     <= RUN;
          end
        end

        RUN: begin
          // Stop is checked first so a stop in the saturating cycle still
          // produces a normal measurement.
          if (stop_pulse) begin
            r_stop_raw <= therm_code;
            r_coarse   <= r_cnt;
            r_timeout  <= 1'b0;
            r_state    <= ENCODE;
          end else if (r_cnt == CNT_MAX) begin
            r_stop_raw <= '0;
            r_coarse   <= CNT_MAX;
            r_timeout  <= 1'b1;
            r_state    <= ENCODE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ENCODE: begin
          r_meas_fine_start <= w_fine_start;
          r_meas_fine_stop  <= w_fine_stop;
          r_meas_coarse     <= r_coarse;
          r_meas_timeout    <= r_timeout;
          r_meas_valid      <= 1'b1;
          r_state           <= DONE;
        end

        DONE: begin
          if (r_meas_valid && meas_ready) begin
            r_meas_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef TDC_DROP_COUNT_EN
  // ---------------------------------------------------------------------------
  // Dropped-pulse counter. Outside IDLE only starts are unusable; inside IDLE
  // only stops are (a start there is always taken). That makes at most one
  // event per cycle, so a same-cycle start+stop in IDLE counts once.
  // ---------------------------------------------------------------------------
  logic [TDC_DROP_W-1:0] r_drop_count;
  logic                  w_drop_evt;

  assign w_drop_evt = (r_state == IDLE) ? stop_pulse : start_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (w_drop_evt && (r_drop_count != {TDC_DROP_W{1'b1}})) begin
      r_drop_count <= r_drop_count + TDC_DROP_W'(1);
    end
  end

  assign drop_count = r_drop_count;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign meas_valid      = r_meas_valid;
  assign meas_coarse     = r_meas_coarse;
  assign meas_fine_start = r_meas_fine_start;
  assign meas_fine_stop  = r_meas_fine_stop;
  assign meas_timeout    = r_meas_timeout;
  assign dbg_state       = r_state;
  assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_tdc_interval_capture.sv
// -----------------------------------------------------------------------------
// tb_tdc_interval_capture
// Bench for tdc_interval_capture with TAPS=8, FINE_W=4, COARSE_W=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// A table of measurement records (directed entries plus randomized ones whose
// expectations come from a small arithmetic model) is replayed in a loop,
// followed by hand-written reset and dropped-pulse sequences.
// -----------------------------------------------------------------------------
module tb_tdc_interval_capture;

  localparam int TAPS     = 8;
  localparam int FINE_W   = 4;
  localparam int COARSE_W = 4;
  localparam int SAT      = (1 << COARSE_W) - 1;
  localparam int N_DIR    = 7;
  localparam int N_RND    = 12;
  localparam int N_VEC    = N_DIR + N_RND;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                clk = 1'b0;
  logic                reset;
  logic                start_pulse;
  logic                stop_pulse;
  logic [TAPS-1:0]     therm_code;
  logic                meas_ready;
  logic                meas_valid;
  logic [COARSE_W-1:0] meas_coarse;
  logic [FINE_W-1:0]   meas_fine_start;
  logic [FINE_W-1:0]   meas_fine_stop;
  logic                meas_timeout;
  logic [1:0]          dbg_state;
  logic                busy;
`ifdef TDC_DROP_COUNT_EN
  logic [15:0]         drop_count;
`endif

  always #5 clk = ~clk;

  tdc_interval_capture #(
    .TAPS     (TAPS),
    .FINE_W   (FINE_W),
    .COARSE_W (COARSE_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start_pulse     (start_pulse),
    .stop_pulse      (stop_pulse),
    .therm_code      (therm_code),
    .meas_ready      (meas_ready),
    .meas_valid      (meas_valid),
    .meas_coarse     (meas_coarse),
    .meas_fine_start (meas_fine_start),
    .meas_fine_stop  (meas_fine_stop),
    .meas_timeout    (meas_timeout),
`ifdef TDC_DROP_COUNT_EN
    .drop_count      (drop_count),
`endif
    .dbg_state       (dbg_state),
    .busy            (busy)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks  = 0;
  int n_fail    = 0;
  int exp_drops = 0;

  typedef struct {
    logic [TAPS-1:0] start_therm;
    logic [TAPS-1:0] stop_therm;
    int              gap;        // edges from start to stop; 0 = no stop
    int              hold;       // cycles of backpressure once valid
    bit              both;       // stop pulse together with the start
    int              exp_coarse;
    int              exp_fs;
    int              exp_fp;
    bit              exp_to;
  } vec_t;

  vec_t vecs [N_VEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: a measurement is fully determined by the two codes and
  // the start-to-stop distance; a missing stop yields the saturated count.
  function automatic vec_t make_vec(input logic [TAPS-1:0] s, input logic [TAPS-1:0] p,
                                    input int gap, input int hold, input bit both);
    vec_t v;
    v.start_therm = s;
    v.stop_therm  = p;
    v.gap         = gap;
    v.hold        = hold;
    v.both        = both;
    v.exp_fs      = $countones(s);
    if (gap == 0 || gap > SAT) begin
      v.exp_coarse = SAT;
      v.exp_fp     = 0;
      v.exp_to     = 1'b1;
    end else begin
      v.exp_coarse = gap;
      v.exp_fp     = $countones(p);
      v.exp_to     = 1'b0;
    end
    return v;
  endfunction

  function automatic vec_t dir_vec(input logic [TAPS-1:0] s, input logic [TAPS-1:0] p,
                                   input int gap, input int hold, input bit both,
                                   input int ec, input int efs, input int efp, input bit eto);
    vec_t v;
    v.start_therm = s;
    v.stop_therm  = p;
    v.gap         = gap;
    v.hold        = hold;
    v.both        = both;
    v.exp_coarse  = ec;
    v.exp_fs      = efs;
    v.exp_fp      = efp;
    v.exp_to      = eto;
    return v;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_valid"},   meas_valid,      0);
    check({tag, "_coarse"},  meas_coarse,     0);
    check({tag, "_fstart"},  meas_fine_start, 0);
    check({tag, "_fstop"},   meas_fine_stop,  0);
    check({tag, "_timeout"}, meas_timeout,    0);
    check({tag, "_busy"},    busy,            0);
    check({tag, "_state"},   dbg_state,       0);
`ifdef TDC_DROP_COUNT_EN
    check({tag, "_drops"},   drop_count,      0);
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one complete measurement with random noise pulses on the way.
  // ---------------------------------------------------------------------------
  task automatic run_vec(input vec_t v);
    int l;
    logic [COARSE_W + 2*FINE_W:0] exp_rec;
    exp_rec = {1'b0, COARSE_W'(v.exp_coarse), FINE_W'(v.exp_fs), FINE_W'(v.exp_fp)};
    exp_rec[COARSE_W + 2*FINE_W] = v.exp_to;
    l = (v.gap == 0) ? SAT : v.gap;

    @(negedge clk);
    therm_code  = v.start_therm;
    start_pulse = 1'b1;
    stop_pulse  = v.both;
    if (v.both) exp_drops++;

    for (int i = 1; i <= l; i++) begin
      @(negedge clk);
      if (i == 1) check("busy_after_start", busy, 1);
      start_pulse = ($urandom_range(0, 3) == 0);
      if (start_pulse) exp_drops++;
      if (v.gap != 0 && i == l) begin
        stop_pulse = 1'b1;
        therm_code = v.stop_therm;
      end else begin
        stop_pulse = 1'b0;
        therm_code = TAPS'($urandom);
      end
    end

    // Stop (or saturation) edge has passed; the next edge is the encode edge.
    @(negedge clk);
    check("valid_early", meas_valid, 0);
    start_pulse = ($urandom_range(0, 1) == 0);
    if (start_pulse) exp_drops++;
    stop_pulse = ($urandom_range(0, 1) == 0);
    therm_code = TAPS'($urandom);

    @(negedge clk);
    check("valid_latency", meas_valid,      1);
    check("coarse",        meas_coarse,     v.exp_coarse);
    check("fine_start",    meas_fine_start, v.exp_fs);
    check("fine_stop",     meas_fine_stop,  v.exp_fp);
    check("timeout",       meas_timeout,    v.exp_to);

    for (int h = 0; h < v.hold; h++) begin
      start_pulse = ($urandom_range(0, 1) == 0);
      if (start_pulse) exp_drops++;
      stop_pulse = ($urandom_range(0, 1) == 0);
      therm_code = TAPS'($urandom);
      @(negedge clk);
      check("hold_valid", meas_valid, 1);
      check("hold_record", {meas_timeout, meas_coarse, meas_fine_start, meas_fine_stop},
            {v.exp_to, exp_rec[COARSE_W + 2*FINE_W - 1:0]});
    end

    start_pulse = 1'b0;
    stop_pulse  = 1'b0;
    meas_ready  = 1'b1;
    @(negedge clk);
    meas_ready = 1'b0;
    check("accept_valid", meas_valid, 0);
    check("accept_busy",  busy,       0);
    check("accept_held", {meas_timeout, meas_coarse, meas_fine_start, meas_fine_stop},
          {v.exp_to, exp_rec[COARSE_W + 2*FINE_W - 1:0]});
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset       = 1'b1;
    start_pulse = 1'b0;
    stop_pulse  = 1'b0;
    therm_code  = '0;
    meas_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Directed records: normal, bubble, backpressure, timeout, stop in the
    // saturating cycle, minimum interval, start+stop together in IDLE.
    vecs[0] = dir_vec(8'b0000_0111, 8'b0011_1111,  5,  0, 1'b0,  5, 3, 6, 1'b0);
    vecs[1] = dir_vec(8'b0000_0111, 8'b0001_0111,  3,  0, 1'b0,  3, 3, 4, 1'b0);
    vecs[2] = dir_vec(8'b1111_1111, 8'b0000_0001,  7, 10, 1'b0,  7, 8, 1, 1'b0);
    vecs[3] = dir_vec(8'b0000_0011, 8'b1111_1111,  0,  2, 1'b0, 15, 2, 0, 1'b1);
    vecs[4] = dir_vec(8'b0000_0001, 8'b1111_1111, 15,  1, 1'b0, 15, 1, 8, 1'b0);
    vecs[5] = dir_vec(8'b0000_0000, 8'b0000_0000,  1,  0, 1'b0,  1, 0, 0, 1'b0);
    vecs[6] = dir_vec(8'b0011_1111, 8'b0000_1111,  4,  0, 1'b1,  4, 6, 4, 1'b0);
    for (int i = N_DIR; i < N_VEC; i++) begin
      vecs[i] = make_vec(TAPS'($urandom), TAPS'($urandom), $urandom_range(0, SAT),
                         $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < N_VEC; i++) begin
      run_vec(vecs[i]);
    end
`ifdef TDC_DROP_COUNT_EN
    check("drops_after_table", drop_count, exp_drops);
`endif

    // Reset in the middle of RUN: record discarded, outputs cleared.
    @(negedge clk);
    start_pulse = 1'b1;
    therm_code  = 8'hFF;
    @(negedge clk);
    start_pulse = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    exp_drops  = 0;
    stop_pulse = 1'b1;   // lone stop in IDLE: ignored
    exp_drops++;
    @(negedge clk);
    stop_pulse = 1'b0;
    check("rst_run_valid",   meas_valid,      0);
    check("rst_run_coarse",  meas_coarse,     0);
    check("rst_run_fstart",  meas_fine_start, 0);
    check("rst_run_fstop",   meas_fine_stop,  0);
    check("rst_run_timeout", meas_timeout,    0);
    check("rst_run_busy",    busy,            0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rst_run_no_valid", meas_valid, 0);
    end
`ifdef TDC_DROP_COUNT_EN
    check("drops_after_reset", drop_count, exp_drops);
`endif

    // Dropped pulses: one lone stop in IDLE, then three starts during RUN.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    stop_pulse = 1'b1;
    @(negedge clk);
    stop_pulse = 1'b0;
    check("stop_alone_idle", busy, 0);
    start_pulse = 1'b1;
    therm_code  = 8'b0000_1111;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      start_pulse = 1'b1;
      therm_code  = 8'b0111_1111;
    end
    @(negedge clk);
    start_pulse = 1'b0;
    stop_pulse  = 1'b1;
    therm_code  = 8'b0000_0011;
    @(negedge clk);
    stop_pulse = 1'b0;
    @(negedge clk);
    check("drop_seq_valid",  meas_valid,      1);
    check("drop_seq_coarse", meas_coarse,     4);
    check("drop_seq_fstart", meas_fine_start, 4);
    check("drop_seq_fstop",  meas_fine_stop,  2);
    meas_ready = 1'b1;
    @(negedge clk);
    meas_ready = 1'b0;
    check("drop_seq_accept", meas_valid, 0);
`ifdef TDC_DROP_COUNT_EN
    check("drop_count_4", drop_count, 4);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero("final_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
